// File: rtl/evict_allocate_ctrl.sv
// Replacement sequencer: optional dirty-victim writeback burst, line fill, then a
// single-cycle allocate write of the filled line into the victim way.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for a replacement request, req_ready high
// S_WB     | streaming the buffered victim line out one beat per handshake
// S_FREQ   | presenting the line-aligned fill address until accepted
// S_FILL   | collecting fill beats into the line buffer
// S_COMMIT | one-cycle allocate write of the filled line, done pulse
module evict_allocate_ctrl #(
    parameter int NUM_WAYS      = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int BEAT_WIDTH    = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [NUM_WAYS-1:0]        req_victim,
    input  logic                       req_dirty,
    input  logic [ADDRESS_WIDTH-1:0]   req_victim_addr,
    input  logic [ADDRESS_WIDTH-1:0]   req_fill_addr,
    input  logic [BLOCK_SIZE*8-1:0]    victim_data,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [ADDRESS_WIDTH-1:0]   wb_addr,
    output logic [BEAT_WIDTH-1:0]      wb_data,
    output logic                       fill_req_valid,
    input  logic                       fill_req_ready,
    output logic [ADDRESS_WIDTH-1:0]   fill_req_addr,
    input  logic                       fill_valid,
    input  logic [BEAT_WIDTH-1:0]      fill_data,
    output logic [NUM_WAYS-1:0]        way_wen,
    output logic [NUM_WAYS-1:0]        way_allocate,
    output logic [BLOCK_SIZE*8-1:0]    way_data,
    output logic                       done,
    output logic                       err
);

    localparam int LINE_W     = BLOCK_SIZE * 8;
    localparam int BEATS      = LINE_W / BEAT_WIDTH;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W      = $clog2(BLOCK_SIZE);
    localparam int BEAT_BYTES = BEAT_WIDTH / 8;

    localparam logic [CNT_W-1:0]         CNT_LAST   = CNT_W'(BEATS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = {ADDRESS_WIDTH{1'b1}} << OFF_W;
    localparam logic [ADDRESS_WIDTH-1:0] BEAT_STEP  = ADDRESS_WIDTH'(BEAT_BYTES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB     = 3'd1;
    localparam logic [2:0] S_FREQ   = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [2:0]                            state;
    logic [CNT_W-1:0]                      cnt;
    logic [NUM_WAYS-1:0]                   victim_q;
    logic [ADDRESS_WIDTH-1:0]              victim_addr_q;
    logic [ADDRESS_WIDTH-1:0]              fill_addr_q;
    // Shared line buffer: holds the victim during WB, then is overwritten beat by beat in FILL.
    logic [BEATS-1:0][BEAT_WIDTH-1:0]      line_buf;
    logic                                  victim_onehot;
    logic                                  last_beat;

    assign victim_onehot = (req_victim != '0) &&
                           ((req_victim & (req_victim - NUM_WAYS'(1))) == '0);
    assign last_beat     = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            victim_q      <= '0;
            victim_addr_q <= '0;
            fill_addr_q   <= '0;
            line_buf      <= '0;
            err           <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (victim_onehot) begin
                            victim_q      <= req_victim;
                            victim_addr_q <= req_victim_addr & ALIGN_MASK;
                            fill_addr_q   <= req_fill_addr & ALIGN_MASK;
                            line_buf      <= victim_data;
                            cnt           <= '0;
                            state         <= req_dirty ? S_WB : S_FREQ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= S_FREQ;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_FREQ: begin
                    if (fill_req_ready) begin
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (fill_valid) begin
                        line_buf[cnt] <= fill_data;
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= S_COMMIT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Data/address outputs are forced to zero outside their own state so nothing leaks on idle buses.
    assign req_ready      = (state == S_IDLE);
    assign wb_valid       = (state == S_WB);
    assign wb_addr        = wb_valid ? (victim_addr_q + ADDRESS_WIDTH'(cnt) * BEAT_STEP) : '0;
    assign wb_data        = wb_valid ? line_buf[cnt] : '0;
    assign fill_req_valid = (state == S_FREQ);
    assign fill_req_addr  = fill_req_valid ? fill_addr_q : '0;
    assign done           = (state == S_COMMIT);
    assign way_wen        = done ? victim_q : '0;
    assign way_allocate   = done ? victim_q : '0;
    assign way_data       = done ? line_buf : '0;

endmodule

// File: tb/tb_evict_allocate_ctrl.sv
// Randomized bench for evict_allocate_ctrl; expectations come from a per-request
// phase model (writeback beats left, fill request pending, fill beats left, commit).
module tb_evict_allocate_ctrl;

    logic           clk;
    logic           reset_n;
    logic           req_valid;
    logic           req_ready;
    logic [3:0]     req_victim;
    logic           req_dirty;
    logic [31:0]    req_victim_addr;
    logic [31:0]    req_fill_addr;
    logic [255:0]   victim_data;
    logic           wb_valid;
    logic           wb_ready;
    logic [31:0]    wb_addr;
    logic [63:0]    wb_data;
    logic           fill_req_valid;
    logic           fill_req_ready;
    logic [31:0]    fill_req_addr;
    logic           fill_valid;
    logic [63:0]    fill_data;
    logic [3:0]     way_wen;
    logic [3:0]     way_allocate;
    logic [255:0]   way_data;
    logic           done;
    logic           err;

    int n_checks = 0;
    int n_errors = 0;

    evict_allocate_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_victim     (req_victim),
        .req_dirty      (req_dirty),
        .req_victim_addr(req_victim_addr),
        .req_fill_addr  (req_fill_addr),
        .victim_data    (victim_data),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .fill_req_valid (fill_req_valid),
        .fill_req_ready (fill_req_ready),
        .fill_req_addr  (fill_req_addr),
        .fill_valid     (fill_valid),
        .fill_data      (fill_data),
        .way_wen        (way_wen),
        .way_allocate   (way_allocate),
        .way_data       (way_data),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic idle_inputs();
        req_valid      = 1'b0;
        req_victim     = '0;
        req_dirty      = 1'b0;
        wb_ready       = 1'b0;
        fill_req_ready = 1'b0;
        fill_valid     = 1'b0;
        fill_data      = '0;
    endtask

    // One idle cycle with a stray fill beat that must be ignored.
    task automatic idle_cycle();
        fill_valid = $urandom_range(0, 1);
        fill_data  = {$urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        fill_valid = 1'b0;
        chk("idle_ready", req_ready, 1'b1);
        chk("idle_done", done, 1'b0);
        chk("idle_wen", way_wen, 4'b0);
    endtask

    // Issues one request and follows it to completion (or to a reset mid-FILL when
    // abort_at >= 0, after that many fill beats). Called and returns at a negedge.
    task automatic do_txn(input logic [3:0] vic, input logic dirty,
                          input logic [31:0] va, input logic [31:0] fa,
                          input logic [255:0] vd, input logic [255:0] fl,
                          input bit stall, input int abort_at, output int lat);
        int          wb_k, fill_k, ph;
        bit          freq_done, got_done;
        logic [31:0] va_al, fa_al;
        va_al     = va & 32'hFFFF_FFE0;
        fa_al     = fa & 32'hFFFF_FFE0;
        wb_k      = 0;
        fill_k    = 0;
        freq_done = 0;
        got_done  = 0;
        lat       = -1;

        idle_cycle();
        req_valid       = 1'b1;
        req_victim      = vic;
        req_dirty       = dirty;
        req_victim_addr = va;
        req_fill_addr   = fa;
        victim_data     = vd;
        @(posedge clk);
        @(negedge clk);

        for (int cyc = 1; cyc <= 300 && !got_done; cyc++) begin
            // Later requests and victim data must not disturb the captured ones.
            req_valid       = $urandom_range(0, 1);
            req_victim      = 4'b1 << $urandom_range(0, 3);
            req_victim_addr = $urandom;
            req_fill_addr   = $urandom;
            victim_data     = rand_line();

            if (dirty && wb_k < 4)  ph = 1;
            else if (!freq_done)    ph = 2;
            else if (fill_k < 4)    ph = 3;
            else                    ph = 4;

            if (abort_at >= 0 && ph == 3 && fill_k == abort_at) begin
                reset_n = 1'b0;
                #1;
                chk("rst_req_ready", req_ready, 1'b1);
                chk("rst_wb_valid", wb_valid, 1'b0);
                chk("rst_wb_data", wb_data, 64'h0);
                chk("rst_freq_valid", fill_req_valid, 1'b0);
                chk("rst_way_wen", way_wen, 4'b0);
                chk("rst_way_alloc", way_allocate, 4'b0);
                chk("rst_way_data", way_data, 256'h0);
                chk("rst_done", done, 1'b0);
                chk("rst_err", err, 1'b0);
                idle_inputs();
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                chk("post_rst_ready", req_ready, 1'b1);
                chk("post_rst_wen", way_wen, 4'b0);
                return;
            end

            chk("req_ready_busy", req_ready, 1'b0);
            chk("err_busy", err, 1'b0);
            chk("wb_valid", wb_valid, ph == 1);
            if (ph == 1) begin
                chk("wb_addr", wb_addr, va_al + 32'(8 * wb_k));
                chk("wb_data", wb_data, vd[64*wb_k +: 64]);
            end
            chk("fill_req_valid", fill_req_valid, ph == 2);
            if (ph == 2) chk("fill_req_addr", fill_req_addr, fa_al);
            chk("done", done, ph == 4);
            chk("way_wen", way_wen, (ph == 4) ? vic : 4'b0);
            chk("way_allocate", way_allocate, (ph == 4) ? vic : 4'b0);
            if (ph == 4) chk("way_data", way_data, fl);

            wb_ready       = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            fill_req_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ph == 3) begin
                fill_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                fill_data  = fl[64*fill_k +: 64];
            end else begin
                fill_valid = $urandom_range(0, 1);
                fill_data  = {$urandom, $urandom};
            end

            @(posedge clk);
            if (ph == 1 && wb_ready)       wb_k++;
            if (ph == 2 && fill_req_ready) freq_done = 1;
            if (ph == 3 && fill_valid)     fill_k++;
            if (ph == 4) begin
                got_done = 1;
                lat      = cyc;
            end
            @(negedge clk);
        end
        idle_inputs();
        chk("txn_timeout", got_done, 1'b1);
        chk("after_ready", req_ready, 1'b1);
        chk("after_done", done, 1'b0);
        chk("after_wen", way_wen, 4'b0);
    endtask

    task automatic do_bad_victim(input logic [3:0] vic);
        idle_cycle();
        req_valid       = 1'b1;
        req_victim      = vic;
        req_dirty       = 1'b1;
        req_victim_addr = $urandom;
        req_fill_addr   = $urandom;
        victim_data     = rand_line();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("err_pulse", err, 1'b1);
        chk("err_ready", req_ready, 1'b1);
        chk("err_wb_valid", wb_valid, 1'b0);
        chk("err_freq_valid", fill_req_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("err_clear", err, 1'b0);
        chk("err_no_wb", wb_valid, 1'b0);
        chk("err_no_freq", fill_req_valid, 1'b0);
        chk("err_ready2", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [255:0] dline;
        reset_n         = 1'b0;
        req_victim_addr = '0;
        req_fill_addr   = '0;
        victim_data     = '0;
        idle_inputs();
        #12;
        chk("reset_ready", req_ready, 1'b1);
        chk("reset_wb_valid", wb_valid, 1'b0);
        chk("reset_freq_valid", fill_req_valid, 1'b0);
        chk("reset_way_wen", way_wen, 4'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_txn(4'b0100, 1'b0, 32'h0, 32'h0000_1234, rand_line(),
               {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b0, -1, lat);
        chk("lat_clean", 32'(lat), 32'd6);

        dline = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        do_txn(4'b0001, 1'b1, 32'h8000_0040, 32'h0000_2000, dline, rand_line(), 1'b0, -1, lat);
        chk("lat_dirty", 32'(lat), 32'd10);

        do_txn(4'b1000, 1'b1, 32'h8000_0040, 32'h0000_3000, dline, rand_line(), 1'b1, -1, lat);

        do_bad_victim(4'b0110);
        do_bad_victim(4'b0000);
        do_bad_victim(4'b1111);

        do_txn(4'b0010, 1'b1, $urandom, $urandom, rand_line(), rand_line(), 1'b0, 2, lat);
        do_txn(4'b0010, 1'b0, 32'h0000_5555, 32'h0000_7777, rand_line(), rand_line(), 1'b0, -1, lat);
        chk("lat_after_rst", 32'(lat), 32'd6);

        for (int t = 0; t < 30; t++) begin
            do_txn(4'b1 << $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, rand_line(), rand_line(), 1'b1, -1, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/evict_allocate_ctrl.md
Name: evict_allocate_ctrl

Overview:
- Sequential eviction/allocation controller between cache way arrays and the memory side.
- Accepts one replacement request: a one-hot victim way, the victim's line data and dirty bit, and the new line address.
- Writes back a dirty victim as a multi-beat burst, fetches the new line as a multi-beat fill, then commits it into the victim way in a single-cycle allocate write.
- Successor to the combinational per-way dataIn mux: adds beat sequencing, buffering, handshakes and parametrised beat width.

Parameters:
- NUM_WAYS, 4, number of ways; victim select is one-hot over this width.
- ADDRESS_WIDTH, 32, byte address width.
- BLOCK_SIZE, 32, line size in bytes (power of 2).
- BEAT_WIDTH, 64, memory beat width in bits. BLOCK_SIZE*8 must be a multiple of BEAT_WIDTH.
- Derived: BEATS = BLOCK_SIZE*8/BEAT_WIDTH, must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  replacement request.
- req_ready  out  1  high only in IDLE.
- req_victim  in  NUM_WAYS  one-hot victim way.
- req_dirty  in  1  victim line is dirty.
- req_victim_addr  in  ADDRESS_WIDTH  victim line address.
- req_fill_addr  in  ADDRESS_WIDTH  new line address.
- victim_data  in  BLOCK_SIZE*8  victim line contents, valid with req_valid.
- wb_valid  out  1  writeback beat valid.
- wb_ready  in  1  writeback beat accepted.
- wb_addr  out  ADDRESS_WIDTH  writeback beat address.
- wb_data  out  BEAT_WIDTH  writeback beat data.
- fill_req_valid  out  1  fill request valid.
- fill_req_ready  in  1  fill request accepted.
- fill_req_addr  out  ADDRESS_WIDTH  line-aligned fill address.
- fill_valid  in  1  fill beat strobe (no backpressure).
- fill_data  in  BEAT_WIDTH  fill beat data.
- way_wen  out  NUM_WAYS  per-way write enable.
- way_allocate  out  NUM_WAYS  per-way allocate strobe.
- way_data  out  BLOCK_SIZE*8  line written to the way.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle invalid-victim pulse.

Behaviour:
- Reset (async, reset_n=0): state IDLE, beat counter 0, buffers 0. All outputs 0 except req_ready=1.
- States: IDLE, WB, FREQ, FILL, COMMIT.
- IDLE, on accept (req_valid&req_ready):
  - Register victim one-hot, both addresses with low log2(BLOCK_SIZE) bits forced to 0, and victim_data into the writeback buffer.
  - Next state WB if req_dirty, else FREQ.
  - If req_victim is zero or multi-hot: stay IDLE, capture nothing, err=1 in the following cycle.
- WB:
  - wb_valid=1; wb_data = beat[cnt], where beat 0 = bits [BEAT_WIDTH-1:0].
  - wb_addr = victim_addr + cnt*(BEAT_WIDTH/8).
  - Outputs held stable until wb_ready.
  - Each handshake increments cnt; on the handshake with cnt=BEATS-1, cnt returns to 0 and state goes to FREQ.
- FREQ: fill_req_valid=1 with fill_req_addr held until fill_req_ready, then FILL.
- FILL:
  - Each fill_valid writes fill_data into buffer beat[cnt] and increments cnt.
  - On beat BEATS-1: cnt returns to 0, state goes to COMMIT.
  - fill_valid in any other state is ignored.
- COMMIT (exactly one cycle): way_wen = way_allocate = victim one-hot, way_data = fill buffer, done=1, then IDLE.
- way_wen/way_allocate are 0 outside COMMIT, so no way is ever written mid-sequence.
- Minimum latency, accept edge to done:
  - Clean: 1 (FREQ) + BEATS + 1 cycles, i.e. done in the 6th cycle after accept for BEATS=4.
  - Dirty: add BEATS cycles.
- BEATS=1: single-beat WB and FILL, counter may be width 1.
- Reset mid-operation: immediate return to IDLE. In-flight beats are dropped; no partial way write occurs.

Test Plan:
- Clean miss, victim 4'b0100, fill_addr 0x0000_1234, ready=1, fill beats 0xA0..A3 back-to-back -> fill_req_addr 0x0000_1220; COMMIT 6 cycles after accept; way_wen=way_allocate=4'b0100; way_data = {A3,A2,A1,A0}; done for 1 cycle.
- Dirty miss, victim_addr 0x8000_0040, victim_data beats {D3..D0} -> wb beats D0..D3 at 0x8000_0040/48/50/58, then fill; done 10 cycles after accept.
- wb_ready toggled 1,0,0,1… -> wb_addr/wb_data stable while stalled; exactly 4 handshakes; no extra beats.
- req_victim=4'b0110 -> err pulse next cycle; req_ready stays 1; no wb/fill activity.
- reset_n low mid-FILL after 2 beats -> all outputs 0 asynchronously, req_ready=1 after release, no way_wen; next request completes normally.
- Stray fill_valid in IDLE/WB -> ignored; COMMIT data contains only beats received in FILL.
